// File: rtl/screen_sel_ctl_pkg.sv
// rtl/screen_sel_ctl_pkg.sv - shared PONG screen ids, palette table and button geometry
package pong_pkg;

    localparam logic [2:0] SCR_MENU = 3'd0;
    localparam logic [2:0] SCR_GAME = 3'd1;
    localparam logic [2:0] SCR_CRED = 3'd2;

    // Entry 7 repeats entry 0 so any 3-bit index lands on a sane colour pair
    localparam logic [11:0] PAL_C1 [8] = '{12'h000, 12'h099, 12'h909, 12'h990,
                                           12'h009, 12'h900, 12'h090, 12'h000};
    localparam logic [11:0] PAL_C2 [8] = '{12'hFFF, 12'hF66, 12'h6F6, 12'h66F,
                                           12'hFF6, 12'h6FF, 12'hF6F, 12'hFFF};

    localparam int BTN_X0_DEF    = 362;
    localparam int BTN_X1_DEF    = 674;
    localparam int BTN_Y0_DEF    = 46;
    localparam int BTN_H_DEF     = 100;
    localparam int BTN_PITCH_DEF = 192;

    typedef enum logic {
        REQ_IDLE,
        REQ_PEND
    } req_state_t;

endpackage

// File: rtl/screen_sel_ctl_if.sv
// rtl/screen_sel_ctl_if.sv - mouse/video bundle between the screen pipelines and the selector
interface screen_sel_ctl_if #(
    parameter int N_SCR = 3
);
    logic [11:0]          xpos;
    logic [11:0]          ypos;
    logic                 mouse_left;
    logic                 back_btn;
    logic                 vblnk_in;
    logic [N_SCR-1:0]     scr_vsync;
    logic [N_SCR-1:0]     scr_hsync;
    logic [12*N_SCR-1:0]  scr_rgb;
    logic                 vsync_out;
    logic                 hsync_out;
    logic [11:0]          rgb_out;
    logic [2:0]           scr_sel;
    logic [3:0]           diff_out;
    logic [11:0]          color1;
    logic [11:0]          color2;

    modport slave (
        input  xpos, ypos, mouse_left, back_btn, vblnk_in, scr_vsync, scr_hsync, scr_rgb,
        output vsync_out, hsync_out, rgb_out, scr_sel, diff_out, color1, color2
    );

    modport master (
        output xpos, ypos, mouse_left, back_btn, vblnk_in, scr_vsync, scr_hsync, scr_rgb,
        input  vsync_out, hsync_out, rgb_out, scr_sel, diff_out, color1, color2
    );

endinterface

// File: rtl/screen_sel_ctl_btn_edge_sync.sv
// rtl/screen_sel_ctl_btn_edge_sync.sv - optional synchroniser chain plus rising-edge pulse
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic lvl;
    logic lvl_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign lvl = btn_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= btn_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign lvl = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
        end
    end

    assign pulse_o = lvl & ~lvl_q;

endmodule

// File: rtl/screen_sel_ctl.sv
// rtl/screen_sel_ctl.sv - PONG screen selector: menu click FSM, vblank-aligned switch, video mux
module screen_sel_ctl
    import pong_pkg::*;
#(
    parameter int N_SCR     = 3,
    parameter int N_DIFF    = 2,
    parameter int N_PAL     = 7,
    parameter int BTN_X0    = BTN_X0_DEF,
    parameter int BTN_X1    = BTN_X1_DEF,
    parameter int BTN_Y0    = BTN_Y0_DEF,
    parameter int BTN_H     = BTN_H_DEF,
    parameter int BTN_PITCH = BTN_PITCH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    screen_sel_ctl_if.slave  bus
);

    logic            click;
    logic            back_pulse;
    logic            vblnk_q;
    logic            vblnk_rise;
    logic            x_in;
    logic [N_SCR:0]  hit;
    logic            req_new;
    logic [2:0]      req_tgt;
    logic [2:0]      mux_idx;

    req_state_t      state_q, state_d;
    logic [2:0]      req_scr_q, req_scr_d;
    logic [2:0]      scr_sel_q, scr_sel_d;
    logic [2:0]      pal_idx_q, pal_idx_d;
    logic [3:0]      diff_q, diff_d;
    logic            vsync_q, hsync_q;
    logic [11:0]     rgb_q, color1_q, color2_q;

    btn_edge_sync #(.SYNC_STAGES(0)) u_mouse_edge (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.mouse_left),
        .pulse_o (click)
    );

    btn_edge_sync #(.SYNC_STAGES(2)) u_back_edge (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.back_btn),
        .pulse_o (back_pulse)
    );

    assign vblnk_rise = bus.vblnk_in & ~vblnk_q;
    assign x_in = (int'(bus.xpos) >= BTN_X0) && (int'(bus.xpos) <= BTN_X1);

    // Button k covers both its top and bottom rows, hence the inclusive BTN_H bound
    for (genvar k = 0; k <= N_SCR; k++) begin : g_hit
        localparam int LO = BTN_Y0 + k * BTN_PITCH;
        assign hit[k] = x_in && (int'(bus.ypos) >= LO) && (int'(bus.ypos) <= LO + BTN_H);
    end

    always_comb begin
        state_d   = state_q;
        req_scr_d = req_scr_q;
        scr_sel_d = scr_sel_q;
        pal_idx_d = pal_idx_q;
        diff_d    = diff_q;
        req_new   = 1'b0;
        req_tgt   = SCR_MENU;

        if (click && scr_sel_q == SCR_MENU && state_q == REQ_IDLE) begin
            if (hit[0]) begin
                req_new = 1'b1;
                req_tgt = SCR_GAME;
            end else if (hit[1]) begin
                diff_d = (diff_q == 4'(N_DIFF - 1)) ? 4'd0 : diff_q + 4'd1;
            end else if (hit[2]) begin
                pal_idx_d = (pal_idx_q == 3'(N_PAL - 1)) ? 3'd0 : pal_idx_q + 3'd1;
            end else begin
                for (int k = 3; k <= N_SCR; k++) begin
                    if (hit[k]) begin
                        req_new = 1'b1;
                        req_tgt = 3'(k - 1);
                    end
                end
            end
        end

        if (back_pulse && scr_sel_q != SCR_MENU) begin
            req_new = 1'b1;
            req_tgt = SCR_MENU;
        end

        if (vblnk_rise && state_q == REQ_PEND) begin
            scr_sel_d = req_scr_q;
            state_d   = REQ_IDLE;
        end

        // A request landing in the commit cycle survives for the next vblank
        if (req_new) begin
            state_d   = REQ_PEND;
            req_scr_d = req_tgt;
        end
    end

    assign mux_idx = (int'(scr_sel_q) < N_SCR) ? scr_sel_q : SCR_MENU;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REQ_IDLE;
            req_scr_q <= SCR_MENU;
            scr_sel_q <= SCR_MENU;
            pal_idx_q <= 3'd0;
            diff_q    <= 4'd0;
            vblnk_q   <= 1'b0;
            vsync_q   <= 1'b0;
            hsync_q   <= 1'b0;
            rgb_q     <= 12'h000;
            color1_q  <= 12'h000;
            color2_q  <= 12'hFFF;
        end else begin
            state_q   <= state_d;
            req_scr_q <= req_scr_d;
            scr_sel_q <= scr_sel_d;
            pal_idx_q <= pal_idx_d;
            diff_q    <= diff_d;
            vblnk_q   <= bus.vblnk_in;
            vsync_q   <= bus.scr_vsync[mux_idx];
            hsync_q   <= bus.scr_hsync[mux_idx];
            rgb_q     <= bus.scr_rgb[12*mux_idx +: 12];
            color1_q  <= PAL_C1[pal_idx_q];
            color2_q  <= PAL_C2[pal_idx_q];
        end
    end

    assign bus.vsync_out = vsync_q;
    assign bus.hsync_out = hsync_q;
    assign bus.rgb_out   = rgb_q;
    assign bus.scr_sel   = scr_sel_q;
    assign bus.diff_out  = diff_q;
    assign bus.color1    = color1_q;
    assign bus.color2    = color2_q;

endmodule
